// File: rtl/uart_byte_rx_if.sv
// Byte-receiver bus: the serial line going in and the byte/strobe outputs
// going to the command parser.
//
// Handshake: byte_valid is a one-cycle strobe with no ready/backpressure.
// data_out is already stable in the cycle byte_valid is high and holds
// until the next good byte. frame_err is a one-cycle strobe that never
// coincides with byte_valid.
interface uart_byte_rx_if;
  logic       rx;
  logic [7:0] data_out;
  logic       byte_valid;
  logic       frame_err;
  logic       busy;

  // The receiver drives the byte side and reads the line.
  modport master (
    input  rx,
    output data_out,
    output byte_valid,
    output frame_err,
    output busy
  );

  // The environment drives the line and consumes bytes.
  modport slave (
    output rx,
    input  data_out,
    input  byte_valid,
    input  frame_err,
    input  busy
  );
endinterface

// File: rtl/uart_byte_rx.sv
// 8N1 UART byte receiver. It samples mid-bit from a synchronised rx, rejects
// start-bit glitches, reports framing errors and waits out break conditions.
module uart_byte_rx #(
  parameter int CLKS_PER_BIT = 10416
) (
  input  logic                  clk,
  input  logic                  rst_n,
  uart_byte_rx_if.master        bus,
  output logic [2:0]            state_dbg
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_DONE      = 3'd4,
    S_WAIT_IDLE = 3'd5
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shift;
  logic            rx_meta;
  logic            rxs;
  logic [7:0]      data_q;
  logic            byte_valid_q;
  logic            frame_err_q;
  logic            busy_q;

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= bus.rx;
      rxs     <= rx_meta;
    end
  end

  // Receive FSM with registered strobes and busy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      cnt          <= '0;
      bit_idx      <= 3'd0;
      shift        <= 8'h00;
      data_q       <= 8'h00;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (!rxs) begin
            state  <= S_START;
            busy_q <= 1'b1;
          end
        end
        S_START: begin
          if (cnt == HALF_M1) begin
            cnt <= '0;
            if (!rxs) begin
              state   <= S_DATA;
              bit_idx <= 3'd0;
            end else begin
              // Start bit vanished before mid-bit: treat as a glitch.
              state  <= S_IDLE;
              busy_q <= 1'b0;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_DATA: begin
          if (cnt == FULL_M1) begin
            cnt            <= '0;
            shift[bit_idx] <= rxs;
            if (bit_idx == 3'd7) begin
              state <= S_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_STOP: begin
          if (cnt == FULL_M1) begin
            cnt <= '0;
            if (rxs) begin
              // Load data on the same edge the strobe rises.
              data_q       <= shift;
              byte_valid_q <= 1'b1;
              state        <= S_DONE;
            end else begin
              frame_err_q <= 1'b1;
              state       <= S_WAIT_IDLE;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_DONE: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
        end
        S_WAIT_IDLE: begin
          // Hold off new starts until the line returns high (break handling).
          if (rxs) begin
            state  <= S_IDLE;
            busy_q <= 1'b0;
          end
        end
        default: begin
          state  <= S_IDLE;
          cnt    <= '0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.data_out   = data_q;
  assign bus.byte_valid = byte_valid_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.busy       = busy_q;
  assign state_dbg      = state;

endmodule

// File: tb/tb_uart_byte_rx.sv
// Bench for uart_byte_rx at 16 clocks per bit: directed frames, scoreboard
// of expected bytes, and a negedge monitor that checks every strobe.
module tb_uart_byte_rx;
  localparam int CPB = 16;
  localparam int NOM_LAT = 2 + CPB / 2 + 9 * CPB + 2;

  logic       clk;
  logic       rst_n;
  logic [2:0] state_dbg;

  uart_byte_rx_if bus ();

  uart_byte_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.master),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [7:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int fe_cnt = 0;
  int bv_cnt = 0;
  int start_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.byte_valid && bus.frame_err) begin
        n_checks++;
        n_errors++;
        $display("FAIL pulse_exclusive: byte_valid and frame_err both high at cycle %0d", cyc);
      end
      if (bus.frame_err) fe_cnt++;
      if (bus.byte_valid) begin
        bv_cnt++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL unexpected_byte: got %0h expected none", bus.data_out);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (bus.data_out !== e) begin
            n_errors++;
            $display("FAIL byte_data: got %0h expected %0h", bus.data_out, e);
          end
        end
        n_checks++;
        if ((cyc - start_cyc) < NOM_LAT - 1 || (cyc - start_cyc) > NOM_LAT + 1) begin
          n_errors++;
          $display("FAIL latency: got %0d expected %0d +/-1", cyc - start_cyc, NOM_LAT);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    if (stop_bit) exp_q.push_back(b);
    @(negedge clk);
    bus.rx = 1'b0;
    start_cyc = cyc;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    bus.rx = stop_bit;
    repeat (CPB) @(negedge clk);
    bus.rx = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_drain(input string name);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 400) begin
      @(negedge clk);
      k++;
    end
    check(name, exp_q.size(), 0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #(100000 * 10);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [7:0] pkt[5];
    int fe0, bv0, k;
    pkt[0] = 8'h21; pkt[1] = 8'h42; pkt[2] = 8'h35; pkt[3] = 8'h31; pkt[4] = 8'h36;

    // Test 1: reset
    bus.rx = 1'b1;
    rst_n  = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_data_out", bus.data_out, 8'h00);
    check("reset_byte_valid", bus.byte_valid, 1'b0);
    check("reset_frame_err", bus.frame_err, 1'b0);
    check("reset_busy", bus.busy, 1'b0);
    check("reset_state", state_dbg, 3'd0);
    idle(200);
    check("reset_quiet_bv", bv_cnt, 0);
    check("reset_quiet_fe", fe_cnt, 0);

    // Test 2: single byte
    send_byte(8'h21, 1'b1);
    idle(20);
    wait_drain("single_drained");
    check("single_bv_count", bv_cnt, 1);
    check("single_data_out", bus.data_out, 8'h21);
    check("single_no_fe", fe_cnt, 0);

    // Test 3: back-to-back packet
    bv0 = bv_cnt;
    for (int i = 0; i < 5; i++) send_byte(pkt[i], 1'b1);
    idle(20);
    wait_drain("stream_drained");
    check("stream_bv_count", bv_cnt - bv0, 5);
    check("stream_last_data", bus.data_out, 8'h36);
    check("stream_no_fe", fe_cnt, 0);

    // Test 4: glitch reject
    bv0 = bv_cnt;
    @(negedge clk);
    bus.rx = 1'b0;
    idle(5);
    bus.rx = 1'b1;
    k = 0;
    @(negedge clk);
    while (bus.busy && k < 10) begin
      @(negedge clk);
      k++;
    end
    check("glitch_busy_drop", bus.busy, 1'b0);
    idle(40);
    check("glitch_no_bv", bv_cnt - bv0, 0);
    check("glitch_no_fe", fe_cnt, 0);
    send_byte(8'h73, 1'b1);
    idle(20);
    wait_drain("glitch_follow_drained");
    check("glitch_follow_data", bus.data_out, 8'h73);

    // Test 5: framing error then break
    bv0 = bv_cnt;
    fe0 = fe_cnt;
    send_byte(8'h61, 1'b0);
    bus.rx = 1'b0;
    idle(400);
    check("break_busy_held", bus.busy, 1'b1);
    bus.rx = 1'b1;
    idle(20);
    check("break_one_fe", fe_cnt - fe0, 1);
    check("break_no_bv", bv_cnt - bv0, 0);
    check("break_data_kept", bus.data_out, 8'h73);
    check("break_busy_clear", bus.busy, 1'b0);
    send_byte(8'h63, 1'b1);
    idle(20);
    wait_drain("break_follow_drained");
    check("break_follow_data", bus.data_out, 8'h63);

    // Test 6: reset in the middle of bit 4 of 0x38
    bv0 = bv_cnt;
    @(negedge clk);
    bus.rx = 1'b0;
    idle(CPB);
    for (int i = 0; i < 4; i++) begin
      bus.rx = pkt[0][i] ^ pkt[0][i] ^ (8'h38 >> i) & 1'b1;
      idle(CPB);
    end
    bus.rx = 1'b1;
    idle(CPB / 2);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midreset_data_out", bus.data_out, 8'h00);
    check("midreset_busy", bus.busy, 1'b0);
    check("midreset_state", state_dbg, 3'd0);
    idle(300);
    check("midreset_no_bv", bv_cnt - bv0, 0);
    send_byte(8'h38, 1'b1);
    idle(20);
    wait_drain("midreset_follow_drained");
    check("midreset_follow_data", bus.data_out, 8'h38);
    check("total_fe", fe_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
